// File: rtl/hub75_rx_monitor.sv
// Panel-side HUB75 receiver: deserializes shifted rows into ping-pong line buffers,
// replays each latched row as pixel writes, and measures OE on-time per latch.
module hub75_rx_monitor #(
  parameter int PANEL_WIDTH   = 32,
  parameter int ROW_ADDR_BITS = 4,
  parameter int BITPLANES     = 4,
  localparam int COL_BITS     = $clog2(PANEL_WIDTH),
  localparam int PLANE_BITS   = $clog2(BITPLANES),
  localparam int ADDR_BITS    = PLANE_BITS + ROW_ADDR_BITS + COL_BITS
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     hub75_clk,
  input  logic                     hub75_lat,
  input  logic                     hub75_oe_,
  input  logic [5:0]               hub75_rgb,
  input  logic [ROW_ADDR_BITS-1:0] hub75_row,
  output logic                     pixel_wr_valid,
  output logic [ADDR_BITS-1:0]     pixel_wr_addr,
  output logic [5:0]               pixel_wr_data,
  output logic                     row_done,
  output logic [ROW_ADDR_BITS-1:0] row_done_row,
  output logic [PLANE_BITS-1:0]    row_done_plane,
  output logic [15:0]              row_done_oe_cycles,
  output logic                     err_col,
  output logic                     err_overrun,
  input  logic                     err_clr
);

  localparam int CNT_BITS = $clog2(PANEL_WIDTH + 1);
  localparam int SYNC_W   = 9 + ROW_ADDR_BITS;
  // Synchronizer idles with OE deasserted so reset release never counts phantom on-time.
  localparam logic [SYNC_W-1:0] SYNC_RST = SYNC_W'(1) << (6 + ROW_ADDR_BITS);

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t                   state, state_next;
  logic [SYNC_W-1:0]        sync1, sync2;
  logic [1:0]               sync3;
  logic                     sclk, slat, soe_;
  logic [5:0]               srgb;
  logic [ROW_ADDR_BITS-1:0] srow;
  logic                     shift_edge, lat_edge, latch_ok, shift_ok;
  logic [CNT_BITS-1:0]      col_cnt, col_after;
  logic [COL_BITS-1:0]      wr_idx, commit_col;
  logic                     wr_sel;
  logic [ROW_ADDR_BITS-1:0] commit_row, last_row;
  logic [PLANE_BITS-1:0]    commit_plane;
  logic [15:0]              oe_cnt, oe_hold;
  logic [5:0]               buf0 [PANEL_WIDTH];
  logic [5:0]               buf1 [PANEL_WIDTH];
  logic [5:0]               rd_data;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
      sync3 <= '0;
    end else begin
      sync1 <= {hub75_clk, hub75_lat, hub75_oe_, hub75_rgb, hub75_row};
      sync2 <= sync1;
      sync3 <= sync2[SYNC_W-1 -: 2];
    end
  end

  assign sclk       = sync2[SYNC_W-1];
  assign slat       = sync2[SYNC_W-2];
  assign soe_       = sync2[SYNC_W-3];
  assign srgb       = sync2[ROW_ADDR_BITS +: 6];
  assign srow       = sync2[ROW_ADDR_BITS-1:0];
  assign shift_edge = sclk & ~sync3[1];
  assign lat_edge   = slat & ~sync3[0];
  assign latch_ok   = lat_edge && (state == IDLE);
  assign shift_ok   = shift_edge && (col_cnt < CNT_BITS'(PANEL_WIDTH));
  assign col_after  = shift_ok ? col_cnt + 1'b1 : col_cnt;
  assign wr_idx     = COL_BITS'(PANEL_WIDTH - 1) - col_cnt[COL_BITS-1:0];
  // Shift fills buffer wr_sel; a commit always replays the other one.
  assign rd_data    = wr_sel ? buf0[commit_col] : buf1[commit_col];

  always_ff @(posedge clk) begin
    if (reset_ && shift_ok) begin
      if (wr_sel) buf1[wr_idx] <= srgb;
      else        buf0[wr_idx] <= srgb;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next         = state;
    pixel_wr_valid     = 1'b0;
    pixel_wr_addr      = '0;
    pixel_wr_data      = '0;
    row_done           = 1'b0;
    row_done_row       = '0;
    row_done_plane     = '0;
    row_done_oe_cycles = '0;
    case (state)
      IDLE: begin
        if (lat_edge) state_next = COMMIT;
      end
      COMMIT: begin
        pixel_wr_valid = 1'b1;
        pixel_wr_addr  = {commit_plane, commit_row, commit_col};
        pixel_wr_data  = rd_data;
        if (commit_col == COL_BITS'(PANEL_WIDTH - 1)) begin
          row_done           = 1'b1;
          row_done_row       = commit_row;
          row_done_plane     = commit_plane;
          row_done_oe_cycles = oe_hold;
          state_next         = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      col_cnt      <= '0;
      wr_sel       <= 1'b0;
      commit_col   <= '0;
      commit_row   <= '0;
      commit_plane <= '0;
      last_row     <= '0;
      oe_cnt       <= '0;
      oe_hold      <= '0;
      err_col      <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      col_cnt <= col_after;
      if (!soe_ && oe_cnt != 16'hFFFF) oe_cnt <= oe_cnt + 16'd1;
      if (state == COMMIT) begin
        if (row_done) commit_col <= '0;
        else          commit_col <= commit_col + 1'b1;
      end
      // A shift coinciding with the latch is already counted in col_after.
      if (latch_ok) begin
        wr_sel       <= ~wr_sel;
        commit_row   <= srow;
        commit_plane <= (srow == last_row) ? commit_plane + 1'b1 : '0;
        last_row     <= srow;
        col_cnt      <= '0;
        oe_hold      <= oe_cnt;
        oe_cnt       <= '0;
        commit_col   <= '0;
      end
      if (latch_ok && col_after != CNT_BITS'(PANEL_WIDTH)) err_col <= 1'b1;
      else if (err_clr)                                    err_col <= 1'b0;
      if (lat_edge && state == COMMIT) err_overrun <= 1'b1;
      else if (err_clr)                err_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hub75_rx_monitor.sv
// Directed bench for hub75_rx_monitor: shifts rows, latches them and checks the
// replayed pixel writes, plane sequencing, OE timing, error flags and reset abort.
module tb_hub75_rx_monitor;
  localparam int PW = 32;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        hub75_clk = 1'b0;
  logic        hub75_lat = 1'b0;
  logic        hub75_oe_ = 1'b1;
  logic [5:0]  hub75_rgb = '0;
  logic [3:0]  hub75_row = '0;
  logic        err_clr = 1'b0;
  logic        pixel_wr_valid;
  logic [10:0] pixel_wr_addr;
  logic [5:0]  pixel_wr_data;
  logic        row_done;
  logic [3:0]  row_done_row;
  logic [1:0]  row_done_plane;
  logic [15:0] row_done_oe_cycles;
  logic        err_col;
  logic        err_overrun;

  hub75_rx_monitor #(.PANEL_WIDTH(PW), .ROW_ADDR_BITS(4), .BITPLANES(4)) dut (
    .clk(clk), .reset_(reset_), .hub75_clk(hub75_clk), .hub75_lat(hub75_lat),
    .hub75_oe_(hub75_oe_), .hub75_rgb(hub75_rgb), .hub75_row(hub75_row),
    .pixel_wr_valid(pixel_wr_valid), .pixel_wr_addr(pixel_wr_addr),
    .pixel_wr_data(pixel_wr_data), .row_done(row_done), .row_done_row(row_done_row),
    .row_done_plane(row_done_plane), .row_done_oe_cycles(row_done_oe_cycles),
    .err_col(err_col), .err_overrun(err_overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge
  int          total_wr = 0;
  int          total_done = 0;
  int          first_cyc = 0;
  int          done_cyc = 0;
  int          done_stamp = 0;
  logic [3:0]  done_row = '0;
  logic [1:0]  done_plane = '0;
  logic [15:0] done_oe = '0;
  logic [5:0]  cap_data [PW];
  logic [10:0] cap_addr [PW];
  int          cap_stamp [PW];

  always @(negedge clk) begin
    if (pixel_wr_valid) begin
      cap_data[pixel_wr_addr[4:0]]  = pixel_wr_data;
      cap_addr[pixel_wr_addr[4:0]]  = pixel_wr_addr;
      cap_stamp[pixel_wr_addr[4:0]] = total_wr;
      if (pixel_wr_addr[4:0] == 5'd0) first_cyc = cyc;
      total_wr++;
    end
    if (row_done) begin
      done_row   = row_done_row;
      done_plane = row_done_plane;
      done_oe    = row_done_oe_cycles;
      done_cyc   = cyc;
      done_stamp = total_wr;
      total_done++;
    end
  end

  int         n_checks = 0;
  int         n_fail = 0;
  int         lat_cyc = 0;
  int         wr_base = 0;
  int         done_base = 0;
  logic [5:0] mbuf0 [PW];
  logic [5:0] mbuf1 [PW];
  logic [5:0] mcommit [PW];
  bit         msel = 1'b0;
  int         mcnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One shift-clock pulse carrying rgb; called on a falling edge, 5 clk long
  task automatic applyStimulus(input logic [5:0] rgb);
    hub75_rgb = rgb;
    @(negedge clk);
    hub75_clk = 1'b1;
    repeat (2) @(negedge clk);
    hub75_clk = 1'b0;
    repeat (2) @(negedge clk);
    if (mcnt < PW) begin
      if (msel) mbuf1[PW-1-mcnt] = rgb;
      else      mbuf0[PW-1-mcnt] = rgb;
      mcnt++;
    end
  endtask

  task automatic shiftRow(input int n, input int base, input int step);
    for (int i = 0; i < n; i++) applyStimulus(6'(base + i * step));
  endtask

  task automatic latchRow(input logic [3:0] row, input bit accept);
    hub75_row = row;
    hub75_lat = 1'b1;
    if (accept) begin
      lat_cyc   = cyc;
      wr_base   = total_wr;
      done_base = total_done;
      for (int c = 0; c < PW; c++) mcommit[c] = msel ? mbuf1[c] : mbuf0[c];
      msel = ~msel;
      mcnt = 0;
    end
    repeat (2) @(negedge clk);
    hub75_lat = 1'b0;
  endtask

  task automatic pulseClear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic verifyCommit(input logic [3:0] row, input logic [1:0] plane, input logic [15:0] oe);
    int ord_err, addr_err, data_err;
    ord_err = 0; addr_err = 0; data_err = 0;
    repeat (40) @(negedge clk);
    checkOutput("wr_count", total_wr - wr_base, 32);
    checkOutput("done_count", total_done - done_base, 1);
    checkOutput("done_row", 32'(done_row), 32'(row));
    checkOutput("done_plane", 32'(done_plane), 32'(plane));
    checkOutput("done_oe", 32'(done_oe), 32'(oe));
    checkOutput("done_with_last", done_stamp, wr_base + 32);
    checkOutput("first_latency", first_cyc - lat_cyc, 3);
    checkOutput("done_latency", done_cyc - lat_cyc, 34);
    for (int c = 0; c < PW; c++) begin
      if (cap_stamp[c] != wr_base + c) ord_err++;
      if (cap_addr[c] !== {plane, row, 5'(c)}) addr_err++;
      if (cap_data[c] !== mcommit[c]) data_err++;
    end
    checkOutput("col_order_errs", ord_err, 0);
    checkOutput("addr_errs", addr_err, 0);
    checkOutput("data_errs", data_err, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(pixel_wr_valid), 0);
    checkOutput("rst_row_done", 32'(row_done), 0);
    checkOutput("rst_addr", 32'(pixel_wr_addr), 0);
    checkOutput("rst_err_col", 32'(err_col), 0);
    checkOutput("rst_err_overrun", 32'(err_overrun), 0);
    reset_ = 1'b1;
    repeat (3) @(negedge clk);

    // Pixel k carries rgb=k, so column c must show 31-c
    shiftRow(32, 0, 1);
    latchRow(4'd5, 1'b1);
    verifyCommit(4'd5, 2'd0, 16'd0);
    checkOutput("t1_col0", 32'(cap_data[0]), 31);
    checkOutput("t1_col10", 32'(cap_data[10]), 21);
    checkOutput("t1_col31", 32'(cap_data[31]), 0);
    checkOutput("t1_err_col", 32'(err_col), 0);
    checkOutput("t1_err_overrun", 32'(err_overrun), 0);

    for (int k = 0; k < 4; k++) begin
      shiftRow(32, 5 + k, 3);
      latchRow(4'd3, 1'b1);
      verifyCommit(4'd3, 2'(k), 16'd0);
    end
    shiftRow(32, 17, 5);
    latchRow(4'd4, 1'b1);
    verifyCommit(4'd4, 2'd0, 16'd0);

    hub75_oe_ = 1'b0;
    repeat (100) @(negedge clk);
    hub75_oe_ = 1'b1;
    shiftRow(32, 9, 7);
    latchRow(4'd6, 1'b1);
    verifyCommit(4'd6, 2'd0, 16'd100);
    hub75_oe_ = 1'b0;
    repeat (70000) @(negedge clk);
    hub75_oe_ = 1'b1;
    shiftRow(32, 2, 11);
    latchRow(4'd6, 1'b1);
    verifyCommit(4'd6, 2'd1, 16'hFFFF);

    // Short rows replay stale entries from the buffer's previous fill
    shiftRow(30, 40, 1);
    latchRow(4'd2, 1'b1);
    verifyCommit(4'd2, 2'd0, 16'd0);
    checkOutput("short30_err_col", 32'(err_col), 1);
    pulseClear();
    checkOutput("clr_err_col", 32'(err_col), 0);
    shiftRow(31, 20, 1);
    latchRow(4'd2, 1'b1);
    verifyCommit(4'd2, 2'd1, 16'd0);
    checkOutput("short31_err_col", 32'(err_col), 1);
    shiftRow(33, 1, 1);
    latchRow(4'd2, 1'b1);
    verifyCommit(4'd2, 2'd2, 16'd0);
    checkOutput("long33_col0", 32'(cap_data[0]), 32);
    checkOutput("long33_col31", 32'(cap_data[31]), 1);
    checkOutput("long33_err_col", 32'(err_col), 1);
    pulseClear();
    checkOutput("clr2_err_col", 32'(err_col), 0);
    checkOutput("pre_err_overrun", 32'(err_overrun), 0);

    shiftRow(32, 3, 1);
    latchRow(4'd7, 1'b1);
    repeat (8) @(negedge clk);
    latchRow(4'd8, 1'b0);
    verifyCommit(4'd7, 2'd0, 16'd0);
    checkOutput("ovr_err_overrun", 32'(err_overrun), 1);
    checkOutput("ovr_err_col", 32'(err_col), 0);

    // Reset while column 10 is on the write port
    shiftRow(32, 0, 3);
    latchRow(4'd9, 1'b1);
    repeat (11) @(negedge clk);
    checkOutput("abort_valid_before", 32'(pixel_wr_valid), 1);
    checkOutput("abort_col_before", 32'(pixel_wr_addr[4:0]), 10);
    reset_ = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", 32'(pixel_wr_valid), 0);
    checkOutput("abort_row_done", 32'(row_done), 0);
    checkOutput("abort_addr", 32'(pixel_wr_addr), 0);
    checkOutput("abort_data", 32'(pixel_wr_data), 0);
    checkOutput("abort_err_overrun", 32'(err_overrun), 0);
    checkOutput("abort_err_col", 32'(err_col), 0);
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    msel = 1'b0;
    mcnt = 0;
    repeat (40) @(negedge clk);
    checkOutput("abort_writes", total_wr - wr_base, 11);
    checkOutput("abort_no_done", total_done - done_base, 0);

    // After reset last_row is 0, so a row-0 latch advances plane to 1
    shiftRow(32, 50, 1);
    latchRow(4'd0, 1'b1);
    verifyCommit(4'd0, 2'd1, 16'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
